// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl: time-of-day counter with a one-shot daily alarm.
// A prescaler divides mclk down to one-second steps that drive an
// hh:mm:ss counter. A small run FSM arms on run_enable, rings when the
// running time reaches the alarm time at second zero, and stops ringing
// on ack or after RING_SEC seconds.
module timer_run_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int RING_SEC      = 60
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       set,
  input  logic [4:0] nowH,
  input  logic [5:0] nowM,
  input  logic [4:0] timerH,
  input  logic [5:0] timerM,
  input  logic       run_enable,
  input  logic       ack,
  output logic [4:0] curH,
  output logic [5:0] curM,
  output logic [5:0] curS,
  output logic       sec_tick,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    DONE    = 2'd3
  } run_state_t;

  run_state_t    cur_state;
  run_state_t    next_state;
  logic [PW-1:0] presc;
  logic [RW-1:0] ring_cnt;
  logic          sec_wrap;
  logic          load_ok;
  logic          time_match;
  logic          ring_done;
  logic [4:0]    adv_h;
  logic [5:0]    adv_m;
  logic [5:0]    adv_s;

  // A load is only honoured when the requested time is a real clock time;
  // out-of-range requests are dropped so the running time is never corrupted.
  assign load_ok    = set && (nowH <= 5'd23) && (nowM <= 6'd59);
  assign sec_wrap   = (presc == PRESC_LAST);
  assign time_match = (curH == timerH) && (curM == timerM) && (curS == 6'd0);
  assign ring_done  = sec_tick && (ring_cnt == RING_LAST);
  assign alarm      = (cur_state == RINGING);
  assign state      = cur_state;

  // Time one second after the current one, with minute/hour/day carries.
  always_comb begin
    adv_h = curH;
    adv_m = curM;
    adv_s = curS + 6'd1;
    if (curS == 6'd59) begin
      adv_s = 6'd0;
      adv_m = curM + 6'd1;
      if (curM == 6'd59) begin
        adv_m = 6'd0;
        adv_h = (curH == 5'd23) ? 5'd0 : curH + 5'd1;
      end
    end
  end

  // Prescaler, second pulse and hh:mm:ss registers; a valid load wins over
  // a coincident second advance and restarts the current second.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      curH     <= 5'd0;
      curM     <= 6'd0;
      curS     <= 6'd0;
    end else if (load_ok) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      curH     <= nowH;
      curM     <= nowM;
      curS     <= 6'd0;
    end else begin
      sec_tick <= sec_wrap;
      if (sec_wrap) begin
        presc <= '0;
        curH  <= adv_h;
        curM  <= adv_m;
        curS  <= adv_s;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Run FSM state register.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; dropping run_enable disarms from anywhere.
  always_comb begin
    next_state = cur_state;
    if (!run_enable) begin
      next_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:    next_state = ARMED;
        ARMED:   if (time_match) next_state = RINGING;
        RINGING: if (ack || ring_done) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Seconds spent ringing: restarted on entry, stepped by each second pulse.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      ring_cnt <= '0;
    end else if ((cur_state != RINGING) && (next_state == RINGING)) begin
      ring_cnt <= '0;
    end else if ((cur_state == RINGING) && sec_tick) begin
      ring_cnt <= ring_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_run_ctrl.sv
// tb_timer_run_ctrl: directed scenarios followed by random traffic, with
// every output compared each cycle against a seconds-of-day reference model.
module tb_timer_run_ctrl;

  localparam int TPS = 4;
  localparam int RS  = 3;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic       set;
  logic [4:0] nowH;
  logic [5:0] nowM;
  logic [4:0] timerH;
  logic [5:0] timerM;
  logic       run_enable;
  logic       ack;
  logic [4:0] curH;
  logic [5:0] curM;
  logic [5:0] curS;
  logic       sec_tick;
  logic       alarm;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, cycle within second.
  int m_sod;
  int m_phase;
  int m_tick;
  int m_state;
  int m_ring;

  timer_run_ctrl #(.TICKS_PER_SEC(TPS), .RING_SEC(RS)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .set        (set),
    .nowH       (nowH),
    .nowM       (nowM),
    .timerH     (timerH),
    .timerM     (timerM),
    .run_enable (run_enable),
    .ack        (ack),
    .curH       (curH),
    .curM       (curM),
    .curS       (curS),
    .sec_tick   (sec_tick),
    .alarm      (alarm),
    .state      (state)
  );

  // Free-running clock.
  always #5 mclk = ~mclk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic modelStep();
    int hh;
    int mm;
    int ss;
    int ns;
    if (!rst_n) begin
      m_sod = 0; m_phase = 0; m_tick = 0; m_state = 0; m_ring = 0;
      return;
    end
    hh = m_sod / 3600;
    mm = (m_sod / 60) % 60;
    ss = m_sod % 60;
    ns = m_state;
    if (!run_enable) ns = 0;
    else if (m_state == 0) ns = 1;
    else if (m_state == 1) begin
      if (hh == int'(timerH) && mm == int'(timerM) && ss == 0) ns = 2;
    end else if (m_state == 2) begin
      if (ack || (m_tick == 1 && m_ring + 1 >= RS)) ns = 3;
    end
    if (ns == 2 && m_state != 2) m_ring = 0;
    else if (m_state == 2 && m_tick == 1) m_ring = m_ring + 1;
    if (set && nowH <= 23 && nowM <= 59) begin
      m_sod = int'(nowH) * 3600 + int'(nowM) * 60;
      m_phase = 0;
      m_tick = 0;
    end else if (m_phase == TPS - 1) begin
      m_sod = (m_sod + 1) % 86400;
      m_phase = 0;
      m_tick = 1;
    end else begin
      m_phase = m_phase + 1;
      m_tick = 0;
    end
    m_state = ns;
  endtask

  task automatic checkOutput();
    checkValue("curH", curH, m_sod / 3600);
    checkValue("curM", curM, (m_sod / 60) % 60);
    checkValue("curS", curS, m_sod % 60);
    checkValue("sec_tick", sec_tick, m_tick);
    checkValue("state", state, m_state);
    checkValue("alarm", alarm, (m_state == 2) ? 1 : 0);
  endtask

  // One clock cycle: drive, clock the model alongside the DUT, then check.
  task automatic applyStimulus(input logic r, input logic s, input int nh, input int nm, input logic a);
    rst_n = r;
    set   = s;
    nowH  = 5'(nh);
    nowM  = 6'(nm);
    ack   = a;
    @(posedge mclk);
    modelStep();
    @(negedge mclk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int ticks;
    int hi;
    int nh;
    int nm;
    rst_n = 1'b0; set = 1'b0; nowH = '0; nowM = '0; ack = 1'b0;
    timerH = 5'd0; timerM = 6'd0; run_enable = 1'b0;
    m_sod = 0; m_phase = 0; m_tick = 0; m_state = 0; m_ring = 0;

    // Reset overrides set, run_enable and ack.
    run_enable = 1'b1;
    applyStimulus(1'b0, 1'b1, 3, 4, 1'b1);
    checkValue("rst_state", state, 0);
    checkValue("rst_curM", curM, 0);
    run_enable = 1'b0;

    // Day rollover from 23:59.
    applyStimulus(1'b1, 1'b1, 23, 59, 1'b0);
    idle(240);
    checkValue("roll_H", curH, 0);
    checkValue("roll_M", curM, 0);
    checkValue("roll_S", curS, 0);

    // Invalid load at 05:10:03 is ignored.
    applyStimulus(1'b1, 1'b1, 5, 10, 1'b0);
    idle(12);
    checkValue("inv_pre_S", curS, 3);
    applyStimulus(1'b1, 1'b1, 24, 0, 1'b0);
    idle(3);
    checkValue("inv_H", curH, 5);
    checkValue("inv_M", curM, 10);
    checkValue("inv_S", curS, 4);

    // Ring timeout after RS seconds.
    timerH = 5'd7; timerM = 6'd30; run_enable = 1'b1;
    applyStimulus(1'b1, 1'b1, 7, 29, 1'b0);
    checkValue("to_armed", state, 1);
    ticks = 0; hi = 0;
    for (int i = 0; i < 260; i++) begin
      idle(1);
      if (alarm === 1'b1) begin
        hi++;
        if (sec_tick === 1'b1) ticks++;
      end
    end
    checkValue("to_ticks", ticks, 3);
    checkValue("to_cycles", hi, 12);
    checkValue("to_done", state, 3);

    // Ack silences; later acks do nothing.
    run_enable = 1'b0; idle(1);
    run_enable = 1'b1;
    applyStimulus(1'b1, 1'b1, 7, 30, 1'b0);
    idle(1);
    checkValue("ack_ring", state, 2);
    idle(1);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    checkValue("ack_done", state, 3);
    checkValue("ack_alarm", alarm, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
    checkValue("ack_late", state, 3);

    // Disarm while ringing, then re-arm.
    run_enable = 1'b0; idle(1);
    run_enable = 1'b1;
    applyStimulus(1'b1, 1'b1, 7, 30, 1'b0);
    idle(1);
    checkValue("dis_ring", state, 2);
    run_enable = 1'b0; idle(1);
    checkValue("dis_idle", state, 0);
    checkValue("dis_alarm", alarm, 0);
    run_enable = 1'b1; idle(1);
    checkValue("dis_rearm", state, 1);

    // Reset in the middle of ringing.
    idle(1);
    checkValue("mr_ring", state, 2);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    checkValue("mr_state", state, 0);
    checkValue("mr_alarm", alarm, 0);
    checkValue("mr_curS", curS, 0);

    // Arming late in the match minute waits for the next day.
    run_enable = 1'b0;
    applyStimulus(1'b1, 1'b1, 7, 30, 1'b0);
    idle(8);
    run_enable = 1'b1;
    idle(20);
    checkValue("late_arm", state, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      nh = $urandom_range(0, 31);
      nm = $urandom_range(0, 63);
      if ($urandom_range(0, 99) == 0) run_enable = ~run_enable;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          timerH = 5'(nh);
          timerM = 6'(nm);
        end
        applyStimulus(($urandom_range(0, 299) != 0), 1'b1, nh, nm, ($urandom_range(0, 9) == 0));
      end else begin
        applyStimulus(($urandom_range(0, 299) != 0), 1'b0, nh, nm, ($urandom_range(0, 9) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_run_ctrl.md
TIMER_RUN_CTRL -- requirements
Module: timer_run_ctrl

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, giving mclk cycles per second (minimum 2).
REQ-002 The block SHALL have parameter RING_SEC, default 60, giving the maximum alarm duration in seconds (minimum 1).
REQ-003 The block SHALL have port mclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port set, input, 1 bit: one-cycle pulse, load the current time from nowH/nowM.
REQ-006 The block SHALL have port nowH, input, 5 bits: hour to load, 0..23.
REQ-007 The block SHALL have port nowM, input, 6 bits: minute to load, 0..59.
REQ-008 The block SHALL have port timerH, input, 5 bits: alarm hour.
REQ-009 The block SHALL have port timerM, input, 6 bits: alarm minute.
REQ-010 The block SHALL have port run_enable, input, 1 bit: level, high = alarm armed by key-entry logic.
REQ-011 The block SHALL have port ack, input, 1 bit: one-cycle pulse, user silences alarm.
REQ-012 The block SHALL have port curH, output, 5 bits: running hour.
REQ-013 The block SHALL have port curM, output, 6 bits: running minute.
REQ-014 The block SHALL have port curS, output, 6 bits: running second.
REQ-015 The block SHALL have port sec_tick, output, 1 bit: one-cycle pulse per second advance.
REQ-016 The block SHALL have port alarm, output, 1 bit: high while ringing.
REQ-017 The block SHALL have port state, output, 2 bits: encoded as IDLE=0, ARMED=1, RINGING=2, DONE=3.

Function
REQ-018 The prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap to 0; sec_tick SHALL be registered high for exactly the cycle after the prescaler held TICKS_PER_SEC-1.
REQ-019 On the edge that wraps the prescaler, curS SHALL increment.
- curS 59->0 increments curM.
- curM 59->0 increments curH.
- curH 23->0.
- 23:59:59 advances to 00:00:00.
REQ-020 set with nowH<=23 and nowM<=59 SHALL, at the next edge, load curH=nowH, curM=nowM, curS=0 and prescaler=0; no sec_tick SHALL occur that cycle.
REQ-021 set with nowH>23 or nowM>59 SHALL be ignored: counters and prescaler keep running unchanged.
REQ-022 set SHALL take priority over a coincident second advance.
REQ-023 The FSM SHALL apply these transitions, evaluated on registered values at each edge:
- IDLE->ARMED when run_enable=1.
- ARMED->RINGING when curH==timerH, curM==timerM and curS==0.
- RINGING->DONE on ack=1, or when RING_SEC sec_ticks have been counted in RINGING.
- DONE holds until run_enable=0.
REQ-024 run_enable=0 SHALL force IDLE from any state at the next edge, with priority over all other transitions.
REQ-025 alarm SHALL equal (state==RINGING), with no extra latency: counters reaching the match at edge k SHALL give state=RINGING and alarm=1 from edge k+1.
REQ-026 The ring-second counter SHALL clear on entry to RINGING and SHALL increment only on sec_tick while in RINGING.
REQ-027 ack outside RINGING SHALL be ignored; ack coinciding with timeout SHALL give DONE (single transition).
REQ-028 Arming while already at the matching minute with curS==0 SHALL ring at the next edge; arming at the match minute with curS!=0 SHALL wait for the next day's match.
REQ-029 set while ARMED or RINGING SHALL reload the counters but SHALL NOT change the FSM state.
REQ-030 The timekeeping counters SHALL run in every FSM state.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL set curH=curM=curS=0, prescaler=0, sec_tick=0, ring counter=0, state=IDLE and alarm=0.
REQ-032 Reset SHALL override set, run_enable and ack in the same cycle.
REQ-033 Reset asserted mid-RINGING SHALL drop alarm at that edge.

Verification (TICKS_PER_SEC=4, RING_SEC=3)
REQ-034 Rollover: set 23:59, run 60 s -> curH:curM:curS = 00:00:00; sec_tick is one cycle wide, every 4th cycle.
REQ-035 Invalid load: set with nowH=24 at time 05:10:03 -> time continues as 05:10:04 with no reload.
REQ-036 Timeout: set 07:29, timerH=7, timerM=30, run_enable=1 -> RINGING one edge after 07:30:00; alarm high for exactly 3 sec_ticks, then state=DONE.
REQ-037 Ack: in RINGING, pulse ack -> state=DONE and alarm=0 at the next edge; a later ack has no effect.
REQ-038 Disarm: run_enable drops while in RINGING -> state=IDLE and alarm=0 at the next edge; re-raising run_enable -> ARMED.
REQ-039 Mid-operation reset: rst_n=0 for one cycle while RINGING -> all outputs 0, state=IDLE.
